golden_nonce_tx: RTL and testbench
==================================

# golden_nonce_tx

Serial transmitter for golden nonces reported by the hash core. It captures each 32-bit `golden_nonce` on its one-cycle `golden_nonce_match` strobe into a small FIFO, then sends each queued nonce to the host as four UART 8N1 bytes. It sits between the hashcore/multicore aggregation and the board serial pin, in the `hash_clk` domain.

## Interface
Parameters:
- `CLK_DIV`, 434: `hash_clk` cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: nonce FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `hash_clk`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `golden_nonce`  in  32  nonce value; valid only when the strobe is high.
- `golden_nonce_match`  in  1  one-cycle strobe; captures `golden_nonce`.
- `txd`  out  1  UART line; idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in flight.
- `overflow`  out  1  sticky; set when a nonce is dropped; cleared only by reset.

## Operation
- FIFO push: `golden_nonce_match`=1 and FIFO not full → write `golden_nonce`, count+1.
- Full FIFO, match, no pop in the same cycle → nonce dropped, `overflow`←1, FIFO unchanged.
- Full FIFO, match and pop in the same cycle → push accepted, count stays at FIFO_DEPTH, no overflow.
- Ordering: strictly FIFO; pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- TX FSM states:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head into a 32-bit shift register, set byte_idx=0, and go to START.
  - START: `txd`=0 for CLK_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: `txd`=current bit for CLK_DIV cycles each, 8 bits LSB first, then go to STOP.
  - STOP: `txd`=1 for CLK_DIV cycles. If byte_idx<3, increment byte_idx and go to START (no gap). Otherwise go to IDLE.
- Byte order: little-endian. Byte0 = nonce[7:0] through byte3 = nonce[31:24].
- Baud counter: counts 0..CLK_DIV-1 and reloads to 0 on every state or bit advance.
- `busy` = (state≠IDLE) | (count≠0). It is registered and updated on the same edge as state/count.
- Reset asserted at any time, including mid-frame:
  - FIFO emptied, state←IDLE, counters←0.
  - `txd`=1, `busy`=0, `overflow`=0 immediately (asynchronous).
  - The partially sent frame is abandoned, not resumed.

## Timing
- Reset values: `txd`=1, `busy`=0, `overflow`=0; FIFO empty.
- Strobe high before edge E → FIFO count updates at E.
- Empty FIFO and IDLE: pop at E+1, and `txd` falls after edge E+1 (2-cycle latency).
- One nonce occupies exactly 40·CLK_DIV cycles of `txd` (4 × 10 bits).
- Back-to-back nonces: 1 IDLE cycle (`txd`=1) between the last stop bit and the next start bit.
- `busy` rises at E and falls on the edge that enters IDLE with an empty FIFO.
- `overflow` sets on the edge that drops the nonce.
- Capacity while a frame is in flight: FIFO_DEPTH queued nonces plus 1 in the shift register.

## Test plan
- **Single nonce:** CLK_DIV=4, reset, strobe `golden_nonce`=0x3FBD91C6 once.
  - `txd` decodes bytes C6, 91, BD, 3F.
  - Low edge 2 cycles after the strobe edge; frame spans 160 cycles.
  - `busy` falls after the last stop bit; `overflow`=0.
- **Burst ordering:** CLK_DIV=4, strobes every 2 cycles with 0x00000001..0x00000004.
  - Four words decode in order.
  - Exactly 1 idle cycle between words; no overflow.
- **Overflow:** CLK_DIV=4, FIFO_DEPTH=4, six strobes spaced 2 cycles apart (0xA0..0xA5) during the first frame.
  - 0xA0..0xA4 are transmitted; 0xA5 is dropped.
  - `overflow` rises on the 6th strobe edge and stays high until reset.
- **Push/pop collision:**
  - Setup: fill the FIFO to 4 while a frame is in flight.
  - Stimulus: strobe 0xBEEF in the exact cycle the FSM pops at IDLE.
  - Response: 0xBEEF is accepted and sent last; `overflow`=0.
- **Reset mid-frame:** assert `rst_n`=0 during byte1 DATA with 2 nonces queued.
  - `txd`=1, `busy`=0, `overflow`=0 asynchronously.
  - After release, no output until a new strobe arrives, which is then sent correctly.
- **Wrap-around:** 3×FIFO_DEPTH nonces paced at one per 40·CLK_DIV+1 cycles (no overflow).
  - All decode in order; pointers wrap cleanly.

Source files
------------

// File: rtl/golden_nonce_tx_if.sv
// Purpose: groups the nonce capture strobe and the serial status outputs of
//          golden_nonce_tx into one bundle.
// Signals:
//   golden_nonce        32-bit nonce, meaningful only while the strobe is high
//   golden_nonce_match  one-cycle capture strobe
//   txd                 UART 8N1 line, idles high
//   busy                FIFO non-empty or a frame in flight
//   overflow            sticky nonce-dropped flag
// Modports:
//   master  producer side (hash core / bench) drives nonce + strobe
//   slave   the transmitter, drives txd / busy / overflow
interface golden_nonce_tx_if;
  logic [31:0] golden_nonce;
  logic        golden_nonce_match;
  logic        txd;
  logic        busy;
  logic        overflow;

  modport master (
    output golden_nonce,
    output golden_nonce_match,
    input  txd,
    input  busy,
    input  overflow
  );

  modport slave (
    input  golden_nonce,
    input  golden_nonce_match,
    output txd,
    output busy,
    output overflow
  );
endinterface

// File: rtl/golden_nonce_tx.sv
// Purpose: captures golden nonces from the hash core into a small FIFO and
//          sends each one to the host as four little-endian UART 8N1 bytes.
// Parameters:
//   CLK_DIV     hash_clk cycles per UART bit (>= 2)
//   FIFO_DEPTH  queued nonce entries (power of 2, >= 2)
// Ports:
//   hash_clk    sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         golden_nonce_tx_if.slave: golden_nonce, golden_nonce_match in;
//               txd, busy, overflow out
module golden_nonce_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               hash_clk,
  input  logic               rst_n,
  golden_nonce_tx_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("golden_nonce_tx: CLK_DIV must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("golden_nonce_tx: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_n;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          overflow_q;

  // transmitter state
  tx_state_t     state;
  tx_state_t     state_n;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [1:0]    byte_idx;
  logic [1:0]    byte_n;
  logic [31:0]   shreg;
  logic [31:0]   shreg_n;
  logic          baud_last;
  logic          txd_q;
  logic          txd_n;
  logic          busy_q;
  logic          busy_n;

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);
  assign baud_last  = (baud_cnt == BAUD_LAST);

  // A full FIFO still accepts a nonce when the transmitter pops in the same
  // cycle, so a drop only happens when there is truly no room.
  always_comb begin
    push    = bus.golden_nonce_match && (!fifo_full || pop);
    drop    = bus.golden_nonce_match && fifo_full && !pop;
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + (AW + 1)'(1);
      2'b01:   count_n = count - (AW + 1)'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge hash_clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.golden_nonce;
  end

  // Next-state logic. The shift register drops one bit per data bit sent,
  // so the LSB is always the next bit on the wire and the bytes come out
  // little-endian without any byte selection.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shreg_n = shreg;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_mem[rd_ptr];
          byte_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[31:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (byte_idx != 2'd3) begin
            byte_n  = byte_idx + 2'd1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
      end
    endcase
  end

  // txd and busy are registered from next-state values so the pin is
  // glitch-free yet changes on the same edge as the state it reflects.
  always_comb begin
    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = shreg_n[0];
      default: txd_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE) || (count_n != '0);
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      shreg    <= shreg_n;
      txd_q    <= txd_n;
      busy_q   <= busy_n;
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Purpose: self-checking bench for golden_nonce_tx with CLK_DIV=4 and
//          FIFO_DEPTH=4. Accepted nonces are queued as expected words; a UART
//          monitor decodes txd independently and compares against the queue.
module tb_golden_nonce_tx;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME_BITS = 40;

  logic hash_clk;
  logic rst_n;

  golden_nonce_tx_if bus ();

  golden_nonce_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .hash_clk (hash_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          gap_check = 1'b0;
  bit          have_prev = 1'b0;
  int          idle_cnt  = 0;

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Caller is at a negedge: the strobe is high across exactly one posedge.
  task automatic applyStimulus(input logic [31:0] nonce, input bit accept);
    bus.golden_nonce       = nonce;
    bus.golden_nonce_match = 1'b1;
    if (accept) exp_q.push_back(nonce);
    @(negedge hash_clk);
    bus.golden_nonce_match = 1'b0;
    bus.golden_nonce       = 32'h0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge hash_clk);
      n++;
    end
    checkOutput("drain_in_budget", 32'(n < budget), 1);
    @(negedge hash_clk);
    @(negedge hash_clk);
    checkOutput("queue_empty", exp_q.size(), 0);
  endtask

  // UART monitor: samples every cycle on the negedge, requires each bit to
  // hold for CLK_DIV cycles, and rebuilds the 32-bit word LSB byte first.
  initial begin : monitor
    logic [31:0] word;
    logic        bitval;
    bit          frame_ok;
    bit          aborted;
    int          b;
    int          pos;
    forever begin
      @(negedge hash_clk);
      if (!rst_n) begin
        idle_cnt  = 0;
        have_prev = 1'b0;
      end else if (bus.txd) begin
        idle_cnt++;
      end else begin
        word     = '0;
        frame_ok = 1'b1;
        aborted  = 1'b0;
        bitval   = 1'b0;
        for (int s = 0; s < FRAME_BITS * CLK_DIV; s++) begin
          if (s > 0) @(negedge hash_clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (s % CLK_DIV == 0) bitval = bus.txd;
          else if (bus.txd !== bitval) frame_ok = 1'b0;
          if (s % CLK_DIV == CLK_DIV - 1) begin
            b   = s / CLK_DIV;
            pos = b % 10;
            if (pos == 0) begin
              if (bitval !== 1'b0) frame_ok = 1'b0;
            end else if (pos == 9) begin
              if (bitval !== 1'b1) frame_ok = 1'b0;
            end else begin
              word[(b / 10) * 8 + pos - 1] = bitval;
            end
          end
        end
        if (aborted) begin
          idle_cnt  = 0;
          have_prev = 1'b0;
        end else begin
          checkOutput("frame_bits", 32'(frame_ok), 1);
          if (gap_check && have_prev) checkOutput("idle_gap", idle_cnt, 1);
          checkOutput("word_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) checkOutput("word", word, exp_q.pop_front());
          have_prev = 1'b1;
          idle_cnt  = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int noisy;
    rst_n                  = 1'b0;
    bus.golden_nonce       = 32'h0;
    bus.golden_nonce_match = 1'b0;
    repeat (3) @(negedge hash_clk);
    checkOutput("reset_txd", bus.txd, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge hash_clk);

    // Single nonce: latency, frame length and busy window
    $display("[TB] single nonce");
    applyStimulus(32'h3FBD91C6, 1'b1);
    checkOutput("t1_busy_rise", bus.busy, 1);
    checkOutput("t1_txd_before_start", bus.txd, 1);
    @(negedge hash_clk);
    checkOutput("t1_start_latency", bus.txd, 0);
    repeat (FRAME_BITS * CLK_DIV - 1) @(negedge hash_clk);
    checkOutput("t1_busy_last_stop", bus.busy, 1);
    checkOutput("t1_txd_last_stop", bus.txd, 1);
    @(negedge hash_clk);
    checkOutput("t1_busy_fall", bus.busy, 0);
    checkOutput("t1_overflow", bus.overflow, 0);
    waitIdle(10);

    // Burst ordering with one idle cycle between words
    $display("[TB] burst ordering");
    gap_check = 1'b1;
    have_prev = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(32'(i), 1'b1);
      @(negedge hash_clk);
    end
    waitIdle(1000);
    checkOutput("t2_overflow", bus.overflow, 0);

    // Overflow: sixth strobe dropped, flag sticky until reset
    $display("[TB] overflow");
    have_prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'hA0 + 32'(i), 1'b1);
      @(negedge hash_clk);
    end
    checkOutput("t3_overflow_before", bus.overflow, 0);
    applyStimulus(32'hA5, 1'b0);
    checkOutput("t3_overflow_set", bus.overflow, 1);
    waitIdle(1000);
    checkOutput("t3_overflow_sticky", bus.overflow, 1);
    rst_n = 1'b0;
    @(negedge hash_clk);
    checkOutput("t3_overflow_cleared", bus.overflow, 0);
    rst_n = 1'b1;
    @(negedge hash_clk);

    // Push/pop collision on a full FIFO
    $display("[TB] push/pop collision");
    have_prev = 1'b0;
    applyStimulus(32'hC0000000, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge hash_clk);
      applyStimulus(32'hC0000000 + 32'(i), 1'b1);
    end
    repeat (153) @(negedge hash_clk);
    checkOutput("t4_idle_slot_txd", bus.txd, 1);
    checkOutput("t4_idle_slot_busy", bus.busy, 1);
    applyStimulus(32'h0000BEEF, 1'b1);
    checkOutput("t4_pop_edge_start", bus.txd, 0);
    checkOutput("t4_no_overflow", bus.overflow, 0);
    waitIdle(2000);
    checkOutput("t4_overflow_end", bus.overflow, 0);

    // Reset in the middle of byte1 data with two nonces queued
    $display("[TB] reset mid-frame");
    gap_check = 1'b0;
    applyStimulus(32'h12340056, 1'b1);
    @(negedge hash_clk);
    applyStimulus(32'h11111111, 1'b1);
    @(negedge hash_clk);
    applyStimulus(32'h22222222, 1'b1);
    repeat (46) @(negedge hash_clk);
    checkOutput("t5_txd_mid_byte1", bus.txd, 0);
    checkOutput("t5_busy_mid_byte1", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_txd", bus.txd, 1);
    checkOutput("t5_async_busy", bus.busy, 0);
    checkOutput("t5_async_overflow", bus.overflow, 0);
    exp_q.delete();
    repeat (3) @(negedge hash_clk);
    rst_n = 1'b1;
    noisy = 0;
    repeat (200) begin
      @(negedge hash_clk);
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) noisy++;
    end
    checkOutput("t5_quiet_after_reset", noisy, 0);
    applyStimulus(32'h5A5AA5A5, 1'b1);
    waitIdle(1000);

    // Wrap-around: 3*FIFO_DEPTH nonces paced one frame plus one cycle apart
    $display("[TB] wrap-around");
    gap_check = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 3 * FIFO_DEPTH; i++) begin
      applyStimulus(32'hD0000000 + 32'(i) * 32'h01010101, 1'b1);
      repeat (FRAME_BITS * CLK_DIV) @(negedge hash_clk);
    end
    waitIdle(1000);
    checkOutput("t6_overflow", bus.overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
